// File: rtl/psum_accumulator.sv
// psum_accumulator: sums VEC_LEN consecutive partial-sum beats from mac_unit
// into one dot-product result held in a one-entry output register.
// Optional feature macro: PSUM_ACC_SAT_EN (saturating adds plus sticky overflow
// flag); when undefined, adds wrap modulo 2^OUT_BITS and out_ovf is tied low.
module psum_accumulator #(
    parameter int ACCUM_BITS = 24,
    parameter int OUT_BITS   = 32,
    parameter int VEC_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACCUM_BITS-1:0] in_psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BITS-1:0]   out_sum,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int CNT_BITS = $clog2(VEC_LEN + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(VEC_LEN - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OUT_BITS-1:0]   r_acc;
    logic [OUT_BITS-1:0]   r_sum;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [OUT_BITS-1:0]   w_add;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last;

    // Input side may accept whenever the output register is empty or draining this cycle
    always_comb begin
        w_in_ready = !rst && ((r_state == ST_ACCUM) || out_ready);
        // A beat offered during clr completes its handshake but is discarded
        w_accept   = in_valid && w_in_ready && !clr;
        w_last     = w_accept && (r_cnt == LAST_CNT);
    end

`ifdef PSUM_ACC_SAT_EN
    logic [OUT_BITS:0] w_wide;
    logic              w_add_ovf;
    logic              r_ovf;
    logic              r_out_ovf;

    // Saturating add: carry out of the accumulator clamps to all ones
    always_comb begin
        w_wide    = {1'b0, r_acc} + (OUT_BITS + 1)'(in_psum);
        w_add_ovf = w_wide[OUT_BITS];
        w_add     = w_add_ovf ? '1 : w_wide[OUT_BITS-1:0];
    end

    // Sticky per-vector overflow bit, cleared together with the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_last ? 1'b0 : (r_ovf | w_add_ovf);
        end
    end

    // Overflow flag travels with the result into the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_ovf <= 1'b0;
        end else if (w_last) begin
            r_out_ovf <= r_ovf | w_add_ovf;
        end
    end

    assign out_ovf = r_out_ovf;
`else
    // Wrapping add modulo 2^OUT_BITS
    always_comb begin
        w_add = r_acc + OUT_BITS'(in_psum);
    end

    assign out_ovf = 1'b0;
`endif

    // Accumulator and beat counter; the last beat restarts both for the next vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_add;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register loads the finished vector sum, unaffected by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_last) begin
            r_sum <= w_add;
        end
    end

    // State register: ACCUM = output register empty, HOLD = output register full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a last beat always (re)fills the output; draining without reload empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end else if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_HOLD);
    assign out_sum   = r_sum;
    assign busy      = (r_cnt != '0);

endmodule
